// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and single-outstanding instruction fetch
// front end. Holds one fetched instruction for decode and retargets on
// control-flow redirects, draining any in-flight response made stale.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (forces redirect targets to
// word alignment and raises a sticky misalign_err).
module fetch_pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_0060),
  parameter int               STEP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_address,
  input  logic             imem_resp,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr,
  input  logic             if_ready,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             redirect_jalr,
  output logic             misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] pc_q,       pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_pc_q,    if_pc_d;
  logic [WIDTH-1:0] if_instr_q, if_instr_d;
  logic             misalign_q, misalign_d;

  // JALR masking first, then optional word alignment of the new PC.
  function automatic logic [WIDTH-1:0] redirect_pc(input logic [WIDTH-1:0] tgt,
                                                   input logic             jalr);
    logic [WIDTH-1:0] t;
    t = tgt;
    if (jalr) t[0] = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  // A target is misaligned if its low two bits are nonzero after the JALR mask.
  function automatic logic redirect_misaligned(input logic [WIDTH-1:0] tgt,
                                               input logic             jalr);
    logic [1:0] lo;
    lo = tgt[1:0];
    if (jalr) lo[0] = 1'b0;
    return |lo;
  endfunction

  // State and datapath registers; everything returns to its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VEC;
      req_addr_q <= RESET_VEC;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state, memory request outputs and redirect override.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    misalign_d   = misalign_q;
    imem_read    = 1'b0;
    imem_address = pc_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_read    = 1'b1;
        imem_address = pc_q;
        req_addr_d   = pc_q;
        if (imem_resp) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + WIDTH'(STEP);
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_DROP: begin
        // The stale request must complete before a new one may issue.
        imem_read    = 1'b1;
        imem_address = req_addr_q;
        if (imem_resp) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      pc_d       = redirect_pc(redirect_target, redirect_jalr);
      if_valid_d = 1'b0;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if ((state_q == S_FETCH) || (state_q == S_DROP))
        state_d = imem_resp ? S_FETCH : S_DROP;
      else
        state_d = S_FETCH;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_misaligned(redirect_target, redirect_jalr)) misalign_d = 1'b1;
`else
      misalign_d = misalign_q & ~redirect_misaligned(redirect_target, redirect_jalr);
`endif
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_instr = if_instr_q;
`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule
